// File: rtl/cond_unit_if.sv
// Flags/branch interface between issue, writeback and the condition unit.
// master = issue/writeback side, slave = cond_unit.
interface cond_unit_if #(
  parameter int FLAGSIZE = 4,
  parameter int PENDW    = 3
);
  logic                issue_sf;
  logic                sf_ready;
  logic                flags_we;
  logic [FLAGSIZE-1:0] flags_in;
  logic                flush;
  logic                br_valid;
  logic                br_ready;
  logic [1:0]          br_kind;
  logic [3:0]          br_cond;
  logic                br_zero;
  logic                res_valid;
  logic                res_taken;
  logic [FLAGSIZE-1:0] flags_out;
  logic [PENDW-1:0]    pending;
  logic                sf_err;

  modport master (
    output issue_sf, flags_we, flags_in, flush,
    output br_valid, br_kind, br_cond, br_zero,
    input  sf_ready, br_ready, res_valid, res_taken, flags_out, pending, sf_err
  );

  modport slave (
    input  issue_sf, flags_we, flags_in, flush,
    input  br_valid, br_kind, br_cond, br_zero,
    output sf_ready, br_ready, res_valid, res_taken, flags_out, pending, sf_err
  );
endinterface

// File: rtl/cond_unit.sv
// LEGv8 branch condition unit: architectural NZVC register, pending flag-writer
// tracking, and branch resolution with a stall for B.cond on in-flight flags.
module cond_unit #(
  parameter int FLAGSIZE = 4,
  parameter int PENDW    = 3
) (
  input logic        clk,
  input logic        rst_n,
  cond_unit_if.slave bus
);

  localparam logic [PENDW-1:0] MAXPEND  = {PENDW{1'b1}};
  localparam logic [PENDW-1:0] PEND_ONE = {{(PENDW-1){1'b0}}, 1'b1};
  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FV = 1;
  localparam int FC = 0;

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [FLAGSIZE-1:0] f);
    logic r;
    case (cond)
      4'h0:    r = f[FZ];
      4'h1:    r = !f[FZ];
      4'h2:    r = f[FC];
      4'h3:    r = !f[FC];
      4'h4:    r = f[FN];
      4'h5:    r = !f[FN];
      4'h6:    r = f[FV];
      4'h7:    r = !f[FV];
      4'h8:    r = f[FC] && !f[FZ];
      4'h9:    r = !(f[FC] && !f[FZ]);
      4'hA:    r = (f[FN] == f[FV]);
      4'hB:    r = (f[FN] != f[FV]);
      4'hC:    r = !f[FZ] && (f[FN] == f[FV]);
      4'hD:    r = !(!f[FZ] && (f[FN] == f[FV]));
      4'hE:    r = 1'b1;
      4'hF:    r = 1'b1;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  state_t              state_r;
  state_t              next_state_s;
  logic [3:0]          cond_r;
  logic [PENDW-1:0]    pending_r;
  logic [FLAGSIZE-1:0] flags_r;
  logic                res_valid_r;
  logic                res_taken_r;
  logic                sf_err_r;

  logic                full_s;
  logic                sf_acc_s;
  logic [PENDW-1:0]    pe_s;
  logic                pe_zero_s;
  logic [FLAGSIZE-1:0] fe_s;
  logic                resolve_s;
  logic                taken_s;
  logic                latch_s;

  // Retiring writer and bypassed flags are seen by the same cycle's branch check.
  assign full_s    = (pending_r == MAXPEND);
  assign sf_acc_s  = bus.issue_sf && !full_s;
  assign pe_s      = (bus.flags_we && (pending_r != {PENDW{1'b0}})) ? (pending_r - PEND_ONE) : pending_r;
  assign pe_zero_s = (pe_s == {PENDW{1'b0}});
  assign fe_s      = bus.flags_we ? bus.flags_in : flags_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.br_valid && (bus.br_kind == 2'b00) && !pe_zero_s && !bus.flush) begin
          next_state_s = WAIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (bus.flush || pe_zero_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output decode: resolve / latch / taken for this cycle
  always_comb begin
    resolve_s = 1'b0;
    taken_s   = 1'b0;
    latch_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.br_valid) begin
          if ((bus.br_kind != 2'b00) || pe_zero_s) begin
            resolve_s = 1'b1;
            case (bus.br_kind)
              2'b00:   taken_s = cond_eval(bus.br_cond, fe_s);
              2'b01:   taken_s = bus.br_zero;
              2'b10:   taken_s = !bus.br_zero;
              2'b11:   taken_s = 1'b1;
              default: taken_s = 1'b0;
            endcase
          end else begin
            latch_s = !bus.flush;
          end
        end else begin
          resolve_s = 1'b0;
        end
      end
      WAIT: begin
        if (!bus.flush && pe_zero_s) begin
          resolve_s = 1'b1;
          taken_s   = cond_eval(cond_r, fe_s);
        end else begin
          resolve_s = 1'b0;
        end
      end
      default: resolve_s = 1'b0;
    endcase
  end

  // Flags register, pending counter, latched condition and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r     <= {FLAGSIZE{1'b0}};
      pending_r   <= {PENDW{1'b0}};
      cond_r      <= 4'h0;
      res_valid_r <= 1'b0;
      res_taken_r <= 1'b0;
      sf_err_r    <= 1'b0;
    end else begin
      if (bus.flags_we) begin
        flags_r <= bus.flags_in;
      end
      if (bus.flush) begin
        pending_r <= {PENDW{1'b0}};
      end else begin
        pending_r <= pe_s + {{(PENDW-1){1'b0}}, sf_acc_s};
      end
      if (latch_s) begin
        cond_r <= bus.br_cond;
      end
      res_valid_r <= resolve_s;
      if (resolve_s) begin
        res_taken_r <= taken_s;
      end
      sf_err_r <= sf_err_r || (bus.issue_sf && full_s);
    end
  end

  assign bus.sf_ready  = !full_s;
  assign bus.br_ready  = (state_r == IDLE);
  assign bus.res_valid = res_valid_r;
  assign bus.res_taken = res_taken_r;
  assign bus.flags_out = flags_r;
  assign bus.pending   = pending_r;
  assign bus.sf_err    = sf_err_r;

endmodule
